neuron_core_lif_seq: RTL and testbench

Parametrised, self-sequencing successor of the tinyODIN LIF neuron core. It owns an N-entry neuron-state SRAM and runs its own FSM to sweep neurons for synaptic events (multiple weights per 32-bit word) and time-reference leak ticks. It emits spikes over a valid/ready handshake and exposes neuron state through an OBI slave that is arbitrated against the sweeps. It sits between the synapse/controller logic and the x-heep OBI bus.

---
 rtl/neuron_core_lif_seq_pkg.sv | 18 +
 rtl/neuron_core_lif_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_neuron_core_lif_seq.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_core_lif_seq_pkg.sv
// OBI request/response payloads for the neuron core slave port.
package neuron_core_lif_seq_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_rsp_t;

endpackage

// File: rtl/neuron_core_lif_seq.sv
// Self-sequencing LIF neuron core: neuron-state SRAM, event/leak sweep FSM,
// spike valid/ready output and an OBI slave arbitrated against the sweeps.
module neuron_core_lif_seq
    import neuron_core_lif_seq_pkg::*;
#(
    parameter int unsigned N       = 256,
    parameter int unsigned STATE_W = 12,
    parameter int unsigned LEAK_W  = 7,
    parameter int unsigned W_W     = 8,
    parameter type         req_t   = obi_req_t,
    parameter type         rsp_t   = obi_rsp_t,
    localparam int unsigned AW     = $clog2(N)
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          evt_valid_i,
    output logic          evt_ready_o,
    input  logic [31:0]   evt_data_i,
    input  logic [AW-1:0] evt_base_i,
    input  logic          tref_i,
    output logic          spike_valid_o,
    input  logic          spike_ready_i,
    output logic [AW-1:0] spike_id_o,
    output logic          busy_o,
    input  req_t          neuroncore_slave_req_i,
    output rsp_t          neuroncore_slave_resp_o
);

    localparam int unsigned WPW   = 32 / W_W;
    localparam int unsigned NW    = 1 + LEAK_W + 2 * STATE_W;
    localparam int unsigned MAXC  = (N > WPW) ? N : WPW;
    localparam int unsigned CW    = $clog2(MAXC);
    localparam int unsigned SUM_W = ((STATE_W > W_W) ? STATE_W : W_W) + 1;
    localparam int unsigned LK_W  = ((STATE_W > LEAK_W + 1) ? STATE_W : LEAK_W + 1) + 1;

    localparam logic signed [STATE_W-1:0] ST_MAX = {1'b0, {(STATE_W-1){1'b1}}};
    localparam logic signed [STATE_W-1:0] ST_MIN = {1'b1, {(STATE_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t        state_q;
    logic          tref_pend_q;
    logic          mode_tref_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   evt_sh_q;
    logic [AW-1:0] evt_base_q;
    logic          spike_valid_q;
    logic [AW-1:0] spike_id_q;
    logic          rvalid_q;
    logic          rd_was_read_q;
    logic [NW-1:0] rd_q;
    logic [NW-1:0] mem_q [N];

    logic          gnt_c;
    logic [AW-1:0] obi_addr_c;
    logic [AW-1:0] cur_addr_c;
    logic          last_c;
    logic          dis_c;
    logic          fire_c;
    logic          fire_wr_c;
    logic          stall_c;
    logic          mem_we_c;
    logic          mem_re_c;
    logic [AW-1:0] mem_waddr_c;
    logic [AW-1:0] mem_raddr_c;
    logic [NW-1:0] mem_wdata_c;

    logic signed [STATE_W-1:0] st_s, thr_s, sat_s, leak_s, new_st_s;
    logic signed [W_W-1:0]     w_s;
    logic signed [SUM_W-1:0]   sum_s;
    logic signed [LK_W-1:0]    st_l, lk_l;
    logic [LEAK_W-1:0]         leak_u;

    // be, address LSBs/MSBs and upper wdata bits carry nothing for this slave
    logic unused_obi;
    assign unused_obi = ^{neuroncore_slave_req_i.be, neuroncore_slave_req_i.addr,
                          neuroncore_slave_req_i.wdata};

    assign obi_addr_c = neuroncore_slave_req_i.addr[2 +: AW];
    assign gnt_c      = neuroncore_slave_req_i.req && (state_q == IDLE);
    assign cur_addr_c = mode_tref_q ? cnt_q[AW-1:0] : evt_base_q + cnt_q[AW-1:0];
    assign last_c     = mode_tref_q ? (cnt_q == CW'(N - 1)) : (cnt_q == CW'(WPW - 1));

    assign evt_ready_o   = (state_q == IDLE) && !neuroncore_slave_req_i.req && !tref_pend_q;
    assign busy_o        = (state_q != IDLE);
    assign spike_valid_o = spike_valid_q;
    assign spike_id_o    = spike_id_q;

    always_comb begin
        neuroncore_slave_resp_o        = '0;
        neuroncore_slave_resp_o.gnt    = gnt_c;
        neuroncore_slave_resp_o.rvalid = rvalid_q;
        neuroncore_slave_resp_o.rdata  = (rvalid_q && rd_was_read_q) ? 32'(rd_q) : 32'd0;
    end

    // Neuron update datapath operating on the word read in RD
    always_comb begin
        dis_c  = rd_q[NW-1];
        leak_u = rd_q[NW-2 -: LEAK_W];
        thr_s  = rd_q[2*STATE_W-1:STATE_W];
        st_s   = rd_q[STATE_W-1:0];
        w_s    = evt_sh_q[W_W-1:0];

        sum_s = SUM_W'(st_s) + SUM_W'(w_s);
        if (sum_s > SUM_W'(ST_MAX)) begin
            sat_s = ST_MAX;
        end else if (sum_s < SUM_W'(ST_MIN)) begin
            sat_s = ST_MIN;
        end else begin
            sat_s = STATE_W'(sum_s);
        end
        fire_c = (sat_s >= thr_s);

        st_l = LK_W'(st_s);
        lk_l = $signed(LK_W'(leak_u));
        if (st_l > lk_l) begin
            leak_s = STATE_W'(st_l - lk_l);
        end else if (st_l < -lk_l) begin
            leak_s = STATE_W'(st_l + lk_l);
        end else begin
            leak_s = '0;
        end

        fire_wr_c = !dis_c && !mode_tref_q && fire_c;
        stall_c   = (state_q == WR) && fire_wr_c && spike_valid_q && !spike_ready_i;

        if (mode_tref_q) begin
            new_st_s = leak_s;
        end else if (fire_c) begin
            new_st_s = '0;
        end else begin
            new_st_s = sat_s;
        end
    end

    // SRAM port steering: OBI in IDLE, sweep read in RD, write-back in WR
    always_comb begin
        mem_we_c    = 1'b0;
        mem_re_c    = 1'b0;
        mem_waddr_c = cur_addr_c;
        mem_raddr_c = cur_addr_c;
        mem_wdata_c = {rd_q[NW-1:STATE_W], new_st_s};
        if (gnt_c) begin
            mem_waddr_c = obi_addr_c;
            mem_raddr_c = obi_addr_c;
            mem_wdata_c = neuroncore_slave_req_i.wdata[NW-1:0];
            mem_we_c    = neuroncore_slave_req_i.we;
            mem_re_c    = !neuroncore_slave_req_i.we;
        end else if (state_q == RD) begin
            mem_re_c = 1'b1;
        end else if (state_q == WR) begin
            mem_we_c = !dis_c && !stall_c;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we_c) begin
            mem_q[mem_waddr_c] <= mem_wdata_c;
        end
        if (mem_re_c) begin
            rd_q <= mem_q[mem_raddr_c];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q       <= IDLE;
            tref_pend_q   <= 1'b0;
            mode_tref_q   <= 1'b0;
            cnt_q         <= '0;
            evt_sh_q      <= '0;
            evt_base_q    <= '0;
            spike_valid_q <= 1'b0;
            spike_id_q    <= '0;
            rvalid_q      <= 1'b0;
            rd_was_read_q <= 1'b0;
        end else begin
            rvalid_q      <= gnt_c;
            rd_was_read_q <= gnt_c && !neuroncore_slave_req_i.we;
            if (tref_i) begin
                tref_pend_q <= 1'b1;
            end
            if (spike_valid_q && spike_ready_i) begin
                spike_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (!neuroncore_slave_req_i.req) begin
                        if (tref_pend_q) begin
                            tref_pend_q <= 1'b0;
                            mode_tref_q <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= RD;
                        end else if (evt_valid_i) begin
                            mode_tref_q <= 1'b0;
                            cnt_q       <= '0;
                            evt_sh_q    <= evt_data_i;
                            evt_base_q  <= evt_base_i;
                            state_q     <= RD;
                        end
                    end
                end
                RD: state_q <= WR;
                WR: begin
                    // a firing neuron waits here while the previous spike is unaccepted
                    if (!stall_c) begin
                        if (fire_wr_c) begin
                            spike_valid_q <= 1'b1;
                            spike_id_q    <= cur_addr_c;
                        end
                        if (!mode_tref_q) begin
                            evt_sh_q <= evt_sh_q >> W_W;
                        end
                        if (last_c) begin
                            state_q <= DONE;
                        end else begin
                            cnt_q   <= cnt_q + CW'(1);
                            state_q <= RD;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_core_lif_seq.sv
// Directed bench for neuron_core_lif_seq with hand-computed neuron words.
module tb_neuron_core_lif_seq;
    import neuron_core_lif_seq_pkg::*;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        evt_valid = 1'b0;
    logic        evt_ready;
    logic [31:0] evt_data = '0;
    logic [7:0]  evt_base = '0;
    logic        tref = 1'b0;
    logic        spike_valid;
    logic        spike_ready = 1'b1;
    logic [7:0]  spike_id;
    logic        busy;
    obi_req_t    req;
    obi_rsp_t    rsp;

    int n_vec = 0;
    int n_err = 0;
    int spk_q[$];
    int sweep_starts = 0;
    logic busy_d = 1'b0;

    always #5 CLK = ~CLK;

    neuron_core_lif_seq dut (
        .CLK                     (CLK),
        .RSTN                    (RSTN),
        .evt_valid_i             (evt_valid),
        .evt_ready_o             (evt_ready),
        .evt_data_i              (evt_data),
        .evt_base_i              (evt_base),
        .tref_i                  (tref),
        .spike_valid_o           (spike_valid),
        .spike_ready_i           (spike_ready),
        .spike_id_o              (spike_id),
        .busy_o                  (busy),
        .neuroncore_slave_req_i  (req),
        .neuroncore_slave_resp_o (rsp)
    );

    // Spike handshakes and sweep starts observed at the clock edge
    always @(posedge CLK) begin
        if (spike_valid && spike_ready) spk_q.push_back(int'(spike_id));
        if (busy && !busy_d) sweep_starts++;
        busy_d = busy;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic int pop_spk();
        if (spk_q.size() == 0) return -1;
        return spk_q.pop_front();
    endfunction

    task automatic obi_write(input int idx, input logic [31:0] data);
        req.req = 1'b1; req.we = 1'b1; req.addr = 32'(idx) << 2; req.wdata = data;
        #1 check_eq("wr_gnt", 32'(rsp.gnt), 32'd1);
        step();
        req.req = 1'b0; req.we = 1'b0;
        check_eq("wr_rvalid", 32'(rsp.rvalid), 32'd1);
        check_eq("wr_rdata", rsp.rdata, 32'd0);
    endtask

    task automatic obi_read(input int idx, output logic [31:0] data);
        req.req = 1'b1; req.we = 1'b0; req.addr = 32'(idx) << 2;
        #1 check_eq("rd_gnt", 32'(rsp.gnt), 32'd1);
        step();
        req.req = 1'b0;
        check_eq("rd_rvalid", 32'(rsp.rvalid), 32'd1);
        data = rsp.rdata;
    endtask

    task automatic check_word(input string tag, input int idx, input logic [31:0] exp);
        logic [31:0] d;
        obi_read(idx, d);
        check_eq(tag, d, exp);
    endtask

    task automatic accept_event(input logic [7:0] base, input logic [31:0] data);
        evt_base = base; evt_data = data; evt_valid = 1'b1;
        #1 check_eq("evt_ready", 32'(evt_ready), 32'd1);
        step();
        evt_valid = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 5000) begin
            cyc++;
            step();
        end
        check_eq("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic pulse_tref();
        tref = 1'b1;
        step();
        tref = 1'b0;
    endtask

    task automatic wait_quiet();
        int low = 0;
        int n = 0;
        while (low < 4 && n < 3000) begin
            step();
            n++;
            if (busy) low = 0; else low++;
        end
        check_eq("quiet_reached", 32'(low >= 4), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int s0;
        req = '0;

        // Reset
        step(); step();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_spike_valid", 32'(spike_valid), 32'd0);
        check_eq("rst_spike_id", 32'(spike_id), 32'd0);
        check_eq("rst_rvalid", 32'(rsp.rvalid), 32'd0);
        RSTN = 1'b1;
        step();
        check_eq("rst_evt_ready", 32'(evt_ready), 32'd1);

        // All neurons disabled, then enable the ones under test
        for (int i = 0; i < 256; i++) obi_write(i, 32'h8000_0000);

        // OBI write/read round trip and two-event fire on neuron 5
        obi_write(5, 32'h000C_8000);
        check_word("obi_rd_n5", 5, 32'h000C_8000);
        accept_event(8'd4, 32'h7F7F_7F7F);
        wait_idle(cyc);
        check_word("n5_after_evt1", 5, 32'h000C_807F);
        check_eq("no_spike_evt1", 32'(spk_q.size()), 32'd0);
        accept_event(8'd4, 32'h7F7F_7F7F);
        wait_idle(cyc);
        check_eq("evt_busy_cycles", 32'(cyc), 32'd9);
        check_eq("spike_n5", 32'(pop_spk()), 32'd5);
        check_word("n5_reset_on_fire", 5, 32'h000C_8000);

        // Saturation both ways: 2040+127 clamps to 2047 and fires at thr 2047
        obi_write(6, 32'h0000_0830);
        obi_write(7, 32'h007F_F7F8);
        accept_event(8'd4, 32'h7F80_0000);
        wait_idle(cyc);
        check_word("n6_sat_neg", 6, 32'h0000_0800);
        check_word("n7_sat_pos_fire", 7, 32'h007F_F000);
        check_eq("spike_n7", 32'(pop_spk()), 32'd7);
        check_eq("spike_cnt_sat", 32'(spk_q.size()), 32'd0);

        // Leak toward zero, clamped at zero
        obi_write(10, 32'h0A00_0005);
        obi_write(11, 32'h0A00_0FFB);
        obi_write(12, 32'h0300_0F9C);
        obi_write(13, 32'h0300_0064);
        pulse_tref();
        step();
        wait_idle(cyc);
        check_eq("tref_busy_cycles", 32'(cyc), 32'd513);
        check_word("leak_pos_clamp", 10, 32'h0A00_0000);
        check_word("leak_neg_clamp", 11, 32'h0A00_0000);
        check_word("leak_neg", 12, 32'h0300_0F9F);
        check_word("leak_pos", 13, 32'h0300_0061);
        check_word("leak0_hold", 6, 32'h0000_0800);
        check_eq("no_spike_leak", 32'(spk_q.size()), 32'd0);

        // Three trefs during a sweep merge into one extra sweep
        s0 = sweep_starts;
        pulse_tref();
        repeat (5) step();
        repeat (3) begin
            pulse_tref();
            repeat (4) step();
        end
        wait_quiet();
        check_eq("tref_merge_sweeps", 32'(sweep_starts - s0), 32'd2);
        check_word("leak_two_sweeps", 13, 32'h0300_005B);

        // Spike back-pressure stalls the second firing neuron
        obi_write(20, 32'h0000_A000);
        obi_write(21, 32'h0000_A000);
        spike_ready = 1'b0;
        accept_event(8'd20, 32'h0000_1414);
        repeat (10) step();
        check_eq("stall_busy", 32'(busy), 32'd1);
        check_eq("stall_valid", 32'(spike_valid), 32'd1);
        check_eq("stall_id", 32'(spike_id), 32'd20);
        req.req = 1'b1; req.we = 1'b0; req.addr = 32'(21) << 2;
        #1 check_eq("gnt_blocked_in_sweep", 32'(rsp.gnt), 32'd0);
        req.req = 1'b0;
        spike_ready = 1'b1;
        wait_idle(cyc);
        step();
        check_eq("bp_spike_first", 32'(pop_spk()), 32'd20);
        check_eq("bp_spike_second", 32'(pop_spk()), 32'd21);
        check_eq("bp_valid_dropped", 32'(spike_valid), 32'd0);
        check_word("bp_n20", 20, 32'h0000_A000);
        check_word("bp_n21", 21, 32'h0000_A000);

        // Base wrap past N-1 with a disabled neuron in the window
        obi_write(254, 32'h007F_F000);
        obi_write(255, 32'h8000_0123);
        obi_write(0, 32'h007F_F000);
        obi_write(1, 32'h007F_F000);
        accept_event(8'd254, 32'h0403_0201);
        wait_idle(cyc);
        check_eq("wrap_busy_cycles", 32'(cyc), 32'd9);
        check_word("wrap_n254", 254, 32'h007F_F001);
        check_word("wrap_n255_disabled", 255, 32'h8000_0123);
        check_word("wrap_n0", 0, 32'h007F_F003);
        check_word("wrap_n1", 1, 32'h007F_F004);

        // Reset mid-sweep aborts before neuron 3 can fire
        obi_write(3, 32'h0000_1000);
        accept_event(8'd0, 32'h0500_0000);
        step(); step();
        RSTN = 1'b0;
        step();
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_spike_valid", 32'(spike_valid), 32'd0);
        RSTN = 1'b1;
        repeat (4) step();
        check_eq("abort_no_spike", 32'(spk_q.size()), 32'd0);
        check_eq("abort_evt_ready", 32'(evt_ready), 32'd1);
        check_word("abort_n3_unchanged", 3, 32'h0000_1000);
        check_word("abort_n0_kept", 0, 32'h007F_F003);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
